// File: rtl/ahb_apb_bridge_mc_pkg.sv
// Shared constants for the AHB-Lite to multi-slave APB4 bridge: FSM encodings,
// AHB transfer/response codes and the write byte-strobe helper.
package ahb_apb_bridge_mc_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Strobe for a (1<<size)-byte beat at byte offset within the bus word; up to 8 lanes.
  function automatic logic [7:0] byte_strobe(input logic [2:0] size, input logic [2:0] offset);
    logic [15:0] mask;
    mask = (16'd1 << (16'd1 << size)) - 16'd1;
    mask = mask << offset;
    return mask[7:0];
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_mc_apb_slv_decoder.sv
// Turns the registered slave index into a one-hot PSEL and steers the selected
// slave's PRDATA/PREADY/PSLVERR back to the bridge.
module apb_slv_decoder #(
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]          idx,
  input  logic                      en,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [NUM_SLV-1:0]        psel,
  output logic [DATA_W-1:0]         prdata_sel,
  output logic                      pready_sel,
  output logic                      pslverr_sel
);

  always_comb begin
    psel        = '0;
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        psel[i]     = en;
        prdata_sel  = prdata[i*DATA_W +: DATA_W];
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to APB4 master bridge with slave decode, byte strobes, error
// responses (decode, size/alignment, PSLVERR, timeout) and back-to-back accepts.
module ahb_apb_bridge_mc
  import ahb_apb_bridge_mc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET_n,
  input  logic                      HSEL,
  input  logic                      HREADYIN,
  input  logic                      HWRITE,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADYOUT,
  output logic [1:0]                HRESP,
  output logic [NUM_SLV-1:0]        PSELx,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  haddr_idx;
  logic [CNT_W-1:0]  to_cnt;
  logic [DATA_W-1:0] hrdata_q;
  logic [DATA_W-1:0] prdata_sel;
  logic              pready_sel;
  logic              pslverr_sel;
  logic              psel_en;
  logic              hready_int;
  logic              accept;
  logic              done_ok;
  logic              rd_done;
  logic              timeout_hit;
  logic              idx_err;
  logic              size_err;
  logic              misalign;
  logic              pre_err;
  logic [7:0]        size_bytes;
  logic [2:0]        align_mask;
  logic [2:0]        offset;
  logic [7:0]        strb_full;
  logic [2:0]        accept_target;
  logic              unused;

  assign unused = ^{HBURST, HTRANS[0]};

  // Address-phase decode and legality checks, evaluated on every candidate accept
  assign haddr_idx  = HADDR[SLV_LSB +: SEL_W];
  assign idx_err    = 32'(haddr_idx) >= NUM_SLV;
  assign size_bytes = 8'd1 << HSIZE;
  assign size_err   = size_bytes > 8'(STRB_W);
  assign align_mask = size_bytes[2:0] - 3'd1;
  assign misalign   = |(HADDR[2:0] & align_mask);
  assign pre_err    = idx_err | size_err | misalign;
  assign offset     = 3'(HADDR[OFF_W-1:0]);
  assign strb_full  = byte_strobe(HSIZE, offset);

  assign done_ok     = (state == ST_ACCESS) && pready_sel && !pslverr_sel;
  assign rd_done     = done_ok && !PWRITE;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == CNT_W'(TO_LAST));
  assign psel_en     = (state == ST_SETUP) || (state == ST_ACCESS);

  always_comb begin
    hready_int = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: hready_int = 1'b1;
      ST_ACCESS:        hready_int = done_ok;
      default:          hready_int = 1'b0;
    endcase
  end

  assign accept = HSEL && HREADYIN && HTRANS[1] && hready_int;

  always_comb begin
    accept_target = ST_SETUP;
    if (pre_err)
      accept_target = ST_ERR1;
    else if (HWRITE)
      accept_target = ST_WDATA;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = accept_target;
      ST_WDATA: state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_sel) begin
          if (pslverr_sel)
            state_nxt = ST_ERR1;
          else if (accept)
            state_nxt = accept_target;
          else
            state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1:  state_nxt = ST_ERR2;
      ST_ERR2:  state_nxt = accept ? accept_target : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control: FSM and wait-state counter
  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_SETUP && state != ST_SETUP)
        to_cnt <= '0;
      else if (state == ST_ACCESS && !pready_sel)
        to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // APB request registers: loaded only by a legal accept, stable through ACCESS
  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      idx_q    <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PSTRB    <= '0;
      PWDATA   <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept && !pre_err) begin
        idx_q  <= haddr_idx;
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PSTRB  <= HWRITE ? strb_full[STRB_W-1:0] : '0;
      end
      if (state == ST_WDATA)
        PWDATA <= HWDATA;
      if (rd_done)
        hrdata_q <= prdata_sel;
    end
  end

  apb_slv_decoder #(
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .idx         (idx_q),
    .en          (psel_en),
    .prdata      (PRDATA),
    .pready      (PREADY),
    .pslverr     (PSLVERR),
    .psel        (PSELx),
    .prdata_sel  (prdata_sel),
    .pready_sel  (pready_sel),
    .pslverr_sel (pslverr_sel)
  );

  assign PENABLE   = (state == ST_ACCESS);
  assign HREADYOUT = hready_int;
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = rd_done ? prdata_sel : hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Directed bench for ahb_apb_bridge_mc: writes, waited reads, slave errors,
// illegal transfers, timeout and asynchronous reset mid-transfer.
module tb_ahb_apb_bridge_mc;

  logic         HCLK;
  logic         HRESET_n;
  logic         HSEL;
  logic         HREADYIN;
  logic         HWRITE;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HADDR;
  logic [31:0]  HWDATA;
  logic [31:0]  HRDATA;
  logic         HREADYOUT;
  logic [1:0]   HRESP;
  logic [3:0]   PSELx;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;

  int checks = 0;
  int errors = 0;

  ahb_apb_bridge_mc #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_LSB(12), .TIMEOUT_CYC(16)
  ) dut (
    .HCLK(HCLK), .HRESET_n(HRESET_n), .HSEL(HSEL), .HREADYIN(HREADYIN),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    HSEL     = 1'b1;
    HREADYIN = 1'b1;
    HTRANS   = 2'b10;
    HWRITE   = wr;
    HADDR    = a;
    HSIZE    = sz;
  endtask

  task automatic ahb_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, 64'(HREADYOUT), 64'd1);
    chk({tag, "_hresp"},     64'(HRESP),     64'd0);
    chk({tag, "_hrdata"},    64'(HRDATA),    64'd0);
    chk({tag, "_psel"},      64'(PSELx),     64'd0);
    chk({tag, "_penable"},   64'(PENABLE),   64'd0);
    chk({tag, "_pwrite"},    64'(PWRITE),    64'd0);
    chk({tag, "_paddr"},     64'(PADDR),     64'd0);
    chk({tag, "_pwdata"},    64'(PWDATA),    64'd0);
    chk({tag, "_pstrb"},     64'(PSTRB),     64'd0);
  endtask

  initial begin
    HRESET_n = 1'b0;
    HSEL = 1'b0; HREADYIN = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'd0; HBURST = 3'd0; HADDR = '0; HWDATA = '0;
    PRDATA  = {32'h3333_3333, 32'h2222_2222, 32'hAAAA_AAAA, 32'hCAFE_0000};
    PREADY  = 4'hF;
    PSLVERR = 4'h0;

    cyc();
    cyc();
    chk_reset_outputs("reset");
    HRESET_n = 1'b1;
    cyc();

    // Word write to slave 1, zero-wait APB slave
    ahb_addr(1'b1, 32'h0000_1004, 3'd2);
    #1 chk("wr_idle_ready", 64'(HREADYOUT), 64'd1);
    cyc();
    ahb_idle();
    HWDATA = 32'hDEAD_BEEF;
    #1 chk("wr_wdata_ready", 64'(HREADYOUT), 64'd0);
    chk("wr_wdata_psel", 64'(PSELx), 64'd0);
    cyc();
    chk("wr_setup_psel",   64'(PSELx),     64'b0010);
    chk("wr_setup_pen",    64'(PENABLE),   64'd0);
    chk("wr_setup_paddr",  64'(PADDR),     64'h1004);
    chk("wr_setup_pwrite", 64'(PWRITE),    64'd1);
    chk("wr_setup_pstrb",  64'(PSTRB),     64'hF);
    chk("wr_setup_pwdata", 64'(PWDATA),    64'hDEAD_BEEF);
    chk("wr_setup_ready",  64'(HREADYOUT), 64'd0);
    cyc();
    chk("wr_access_pen",   64'(PENABLE),   64'd1);
    chk("wr_access_ready", 64'(HREADYOUT), 64'd1);
    chk("wr_access_hresp", 64'(HRESP),     64'd0);
    cyc();
    chk("wr_done_psel", 64'(PSELx),   64'd0);
    chk("wr_done_pen",  64'(PENABLE), 64'd0);

    // Read slave 2 with its PREADY low for three ACCESS cycles
    PRDATA[95:64] = 32'h0000_1234;
    PREADY = 4'b1011;
    ahb_addr(1'b0, 32'h0000_2008, 3'd2);
    cyc();
    ahb_idle();
    #1 chk("rd_setup_psel",  64'(PSELx),     64'b0100);
    chk("rd_setup_pen",    64'(PENABLE),   64'd0);
    chk("rd_setup_pwrite", 64'(PWRITE),    64'd0);
    chk("rd_setup_pstrb",  64'(PSTRB),     64'd0);
    chk("rd_setup_paddr",  64'(PADDR),     64'h2008);
    chk("rd_setup_ready",  64'(HREADYOUT), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_wait", 64'({PSELx, PENABLE, HREADYOUT}), 64'({4'b0100, 1'b1, 1'b0}));
    end
    cyc();
    PREADY = 4'hF;
    #1 chk("rd_done_ready", 64'(HREADYOUT), 64'd1);
    chk("rd_done_hrdata", 64'(HRDATA), 64'h1234);
    chk("rd_done_hresp",  64'(HRESP),  64'd0);
    cyc();
    PRDATA[95:64] = 32'h0000_5555;
    #1 chk("rd_hold_hrdata", 64'(HRDATA), 64'h1234);
    chk("rd_hold_psel", 64'(PSELx), 64'd0);

    // Halfword write to slave 3 upper lanes, slave answers with PSLVERR
    ahb_addr(1'b1, 32'h0000_3002, 3'd1);
    cyc();
    ahb_idle();
    HWDATA = 32'hBEEF_0000;
    cyc();
    chk("err_setup_psel",   64'(PSELx),  64'b1000);
    chk("err_setup_pstrb",  64'(PSTRB),  64'b1100);
    chk("err_setup_pwdata", 64'(PWDATA), 64'hBEEF_0000);
    PSLVERR = 4'b1000;
    cyc();
    chk("err_access_ready", 64'(HREADYOUT), 64'd0);
    chk("err_access_hresp", 64'(HRESP),     64'd0);
    cyc();
    chk("err1_hresp", 64'(HRESP),     64'd1);
    chk("err1_ready", 64'(HREADYOUT), 64'd0);
    chk("err1_psel",  64'(PSELx),     64'd0);
    cyc();
    PSLVERR = 4'h0;
    ahb_addr(1'b0, 32'h0000_0010, 3'd2);
    #1 chk("err2_hresp", 64'(HRESP),     64'd1);
    chk("err2_ready", 64'(HREADYOUT), 64'd1);
    cyc();
    ahb_idle();
    #1 chk("err2_accept_psel", 64'(PSELx), 64'b0001);
    chk("err2_accept_hresp", 64'(HRESP), 64'd0);
    cyc();
    chk("err2_rd_hrdata", 64'(HRDATA), 64'hCAFE_0000);
    chk("err2_rd_ready",  64'(HREADYOUT), 64'd1);
    cyc();

    // Oversized transfer (8 bytes on a 32-bit bus)
    ahb_addr(1'b0, 32'h0000_1000, 3'd3);
    cyc();
    ahb_idle();
    #1 chk("size_err1_psel",  64'(PSELx),     64'd0);
    chk("size_err1_hresp", 64'(HRESP),     64'd1);
    chk("size_err1_ready", 64'(HREADYOUT), 64'd0);
    cyc();
    chk("size_err2_hresp", 64'(HRESP),     64'd1);
    chk("size_err2_ready", 64'(HREADYOUT), 64'd1);
    // Misaligned word write accepted straight out of ERR2
    ahb_addr(1'b1, 32'h0000_1002, 3'd2);
    cyc();
    ahb_idle();
    #1 chk("align_err1_psel",  64'(PSELx),   64'd0);
    chk("align_err1_pen",   64'(PENABLE), 64'd0);
    chk("align_err1_hresp", 64'(HRESP),   64'd1);
    cyc();
    cyc();
    chk("align_idle_hresp", 64'(HRESP), 64'd0);
    chk("align_idle_psel",  64'(PSELx), 64'd0);

    // Transfers that must be ignored: HREADYIN low, then BUSY
    ahb_addr(1'b0, 32'h0000_1000, 3'd2);
    HREADYIN = 1'b0;
    cyc();
    chk("nohready_psel",  64'(PSELx),     64'd0);
    chk("nohready_ready", 64'(HREADYOUT), 64'd1);
    HREADYIN = 1'b1;
    HTRANS = 2'b01;
    cyc();
    chk("busy_psel", 64'(PSELx), 64'd0);
    ahb_idle();

    // Slave 1 never ready: timeout after 16 ACCESS cycles
    PREADY = 4'b0000;
    ahb_addr(1'b0, 32'h0000_1000, 3'd2);
    cyc();
    ahb_idle();
    #1 chk("to_setup_psel", 64'(PSELx), 64'b0010);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("to_access", 64'({PSELx, PENABLE, HREADYOUT}), 64'({4'b0010, 1'b1, 1'b0}));
    end
    cyc();
    chk("to_err1_psel",  64'(PSELx),     64'd0);
    chk("to_err1_pen",   64'(PENABLE),   64'd0);
    chk("to_err1_hresp", 64'(HRESP),     64'd1);
    chk("to_err1_ready", 64'(HREADYOUT), 64'd0);
    cyc();
    chk("to_err2_hresp", 64'(HRESP),     64'd1);
    chk("to_err2_ready", 64'(HREADYOUT), 64'd1);
    cyc();
    PREADY = 4'hF;

    // Back-to-back reads, then reset while the second is in ACCESS
    PRDATA[31:0] = 32'h1111_1111;
    ahb_addr(1'b0, 32'h0000_0004, 3'd2);
    cyc();
    ahb_idle();
    cyc();
    ahb_addr(1'b0, 32'h0000_3008, 3'd2);
    #1 chk("b2b_first_ready",  64'(HREADYOUT), 64'd1);
    chk("b2b_first_hrdata", 64'(HRDATA),    64'h1111_1111);
    cyc();
    ahb_idle();
    PREADY = 4'b0111;
    #1 chk("b2b_second_psel",  64'(PSELx), 64'b1000);
    chk("b2b_second_paddr", 64'(PADDR), 64'h3008);
    cyc();
    chk("b2b_second_access", 64'({PSELx, PENABLE, HREADYOUT}), 64'({4'b1000, 1'b1, 1'b0}));
    #1 HRESET_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    cyc();
    HRESET_n = 1'b1;
    PREADY = 4'hF;
    cyc();
    chk("post_reset_ready", 64'(HREADYOUT), 64'd1);
    chk("post_reset_psel",  64'(PSELx),     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
